// File: rtl/haar_butterfly_stage_16bit.sv
// Haar butterfly feeder: buffers the first half of each frame, emits sum/diff pairs
// and tracks the downstream 1/sqrt(2) multiplier latency. Optional macro: DB_SAT_EN.
module haar_butterfly_stage_16bit #(
  parameter int N        = 8,
  parameter int MULT_LAT = 3,
  parameter int IDXW     = (N > 2) ? $clog2(N / 2) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [15:0]     sum_out,
  output logic [15:0]     diff_out,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            mult_en,
  output logic            scaled_valid
`ifdef DB_SAT_EN
  ,
  output logic            sat_flag
`endif
);

  localparam int HALF = N / 2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(HALF - 1);

  typedef enum logic {FILL, PAIR} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] cnt, cnt_nxt;
  logic            xfer;
  logic            pair_load;
  logic            out_xfer;

  logic signed [15:0] buf_mem [HALF];
  logic signed [15:0] a_p0, b_p0;
  logic signed [15:0] sum_p0, diff_p0;
  logic [MULT_LAT-1:0] vld_sr;

`ifdef DB_SAT_EN
  logic signed [16:0] sum_w_p0, diff_w_p0;
  logic               sat_p0;

  function automatic logic is_ovf(input logic signed [16:0] v);
    return v[16] != v[15];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15])
      return v[16] ? 16'sh8000 : 16'sh7fff;
    return v[15:0];
  endfunction
`endif

  assign xfer      = in_valid && in_ready;
  assign pair_load = xfer && (state == PAIR);
  assign out_xfer  = out_valid && out_ready;
  assign mult_en   = out_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b1;
    if (state == PAIR)
      in_ready = !out_valid || out_ready;
    if (in_valid && in_ready) begin
      if (cnt == LAST_IDX) begin
        cnt_nxt   = '0;
        state_nxt = (state == FILL) ? PAIR : FILL;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // First-half samples wait here until their partner arrives
  always_ff @(posedge clk) begin
    if (xfer && (state == FILL))
      buf_mem[cnt] <= signed'(in_data);
  end

  // Stage p0: butterfly arithmetic on buffered and incoming sample
  always_comb begin
    a_p0 = buf_mem[cnt];
    b_p0 = signed'(in_data);
`ifdef DB_SAT_EN
    sum_w_p0  = {a_p0[15], a_p0} + {b_p0[15], b_p0};
    diff_w_p0 = {a_p0[15], a_p0} - {b_p0[15], b_p0};
    sum_p0    = sat16(sum_w_p0);
    diff_p0   = sat16(diff_w_p0);
    sat_p0    = is_ovf(sum_w_p0) || is_ovf(diff_w_p0);
`else
    sum_p0    = a_p0 + b_p0;
    diff_p0   = a_p0 - b_p0;
`endif
  end

  // Stage p1: registered output with valid/ready hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_out   <= '0;
      diff_out  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
`ifdef DB_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else if (pair_load) begin
      sum_out   <= sum_p0;
      diff_out  <= diff_p0;
      out_idx   <= cnt;
      out_last  <= (cnt == LAST_IDX);
      out_valid <= 1'b1;
`ifdef DB_SAT_EN
      sat_flag  <= sat_p0;
`endif
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Valid shadow of the multiplier pipeline; advances only when it does
  generate
    if (MULT_LAT > 1) begin : g_sr
      always_ff @(posedge clk) begin
        if (!rst)
          vld_sr <= '0;
        else if (mult_en)
          vld_sr <= {vld_sr[MULT_LAT-2:0], out_xfer};
      end
    end else begin : g_sr1
      always_ff @(posedge clk) begin
        if (!rst)
          vld_sr <= '0;
        else if (mult_en)
          vld_sr <= out_xfer;
      end
    end
  endgenerate

  assign scaled_valid = vld_sr[MULT_LAT-1];

endmodule

// File: tb/tb_haar_butterfly_stage_16bit.sv
// Scoreboard bench for haar_butterfly_stage_16bit (N=8, MULT_LAT=3); honours DB_SAT_EN.
module tb_haar_butterfly_stage_16bit;

  localparam int N    = 8;
  localparam int HALF = N / 2;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [15:0]     in_data;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     sum_out;
  logic [15:0]     diff_out;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic            mult_en;
  logic            scaled_valid;
`ifdef DB_SAT_EN
  logic            sat_flag;
`endif

  haar_butterfly_stage_16bit #(.N(N), .MULT_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sum_out(sum_out), .diff_out(diff_out), .out_idx(out_idx),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .mult_en(mult_en), .scaled_valid(scaled_valid)
`ifdef DB_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] s;
    logic [15:0] d;
    logic [1:0]  idx;
    logic        last;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   pass  = 0;
  int   cyc   = 0;
  int   track = 0;
  int   seen  = 0;
  int   last_cyc = 0;
  int   max_gap  = 0;
  int   out_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [15:0] s, input logic [15:0] d, input int idx, input logic sat);
    exp_t e;
    e.s = s; e.d = d; e.idx = idx[1:0]; e.last = (idx == HALF - 1); e.sat = sat;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] d);
    int g;
    g = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      g++;
      if (g > 100) begin
        total++;
        $display("FAIL send_timeout: sample %0h not accepted", d);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: pops the scoreboard on every output transfer
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got sum %0h idx %0d, expected none", sum_out, out_idx);
      end else begin
        e = sb.pop_front();
        chk("sum", {16'b0, sum_out}, {16'b0, e.s});
        chk("diff", {16'b0, diff_out}, {16'b0, e.d});
        chk("idx", {30'b0, out_idx}, {30'b0, e.idx});
        chk("last", {31'b0, out_last}, {31'b0, e.last});
`ifdef DB_SAT_EN
        chk("sat", {31'b0, sat_flag}, {31'b0, e.sat});
`endif
      end
      if (track != 0) begin
        if (seen != 0 && (cyc - last_cyc) > max_gap) max_gap = cyc - last_cyc;
        last_cyc = cyc;
        seen = 1;
        out_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_sum", {16'b0, sum_out}, 0);
    chk("rst_diff", {16'b0, diff_out}, 0);
    chk("rst_idx", {30'b0, out_idx}, 0);
    chk("rst_last", {31'b0, out_last}, 0);
    chk("rst_scaled", {31'b0, scaled_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;

    // Test 1: one frame, continuous flow
    push(6, 16'hfffc, 0, 0); push(8, 16'hfffc, 1, 0);
    push(10, 16'hfffc, 2, 0); push(12, 16'hfffc, 3, 0);
    for (int i = 1; i <= 8; i++) send(16'(i));
    idle(6);

    // Test 2: consumer stall after the first output
    push(6, 16'hfffc, 0, 0); push(8, 16'hfffc, 1, 0);
    push(10, 16'hfffc, 2, 0); push(12, 16'hfffc, 3, 0);
    for (int i = 1; i <= 5; i++) send(16'(i));
    fork
      begin
        for (int i = 6; i <= 8; i++) send(16'(i));
      end
      begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", {31'b0, out_valid}, 1);
          chk("stall_sum", {16'b0, sum_out}, 6);
          chk("stall_in_ready", {31'b0, in_ready}, 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(6);

    // Test 3: overflow boundaries
`ifdef DB_SAT_EN
    push(16'h7fff, 16'h7ffe, 0, 1); push(16'h8001, 16'h8000, 1, 1);
`else
    push(16'h8000, 16'h7ffe, 0, 0); push(16'h8001, 16'h7fff, 1, 0);
`endif
    push(0, 0, 2, 0); push(0, 0, 3, 0);
    send(16'h7fff); send(16'h8000); send(0); send(0);
    send(1); send(1); send(0); send(0);
    idle(6);

    // Test 4: scaled_valid timing, free-running then with a 2-cycle stall
    push(6, 16'hfffc, 0, 0); push(8, 16'hfffc, 1, 0);
    push(10, 16'hfffc, 2, 0); push(12, 16'hfffc, 3, 0);
    for (int i = 1; i <= 5; i++) send(16'(i));
    in_valid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_t%0d", k), {31'b0, scaled_valid}, (k == 3) ? 1 : 0);
    end
    @(posedge clk); #1;
    send(16'd6);
    in_valid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("stall_lat_t%0d", k), {31'b0, scaled_valid}, (k == 5) ? 1 : 0);
      @(posedge clk); #1;
      out_ready = (k == 0 || k == 1) ? 1'b0 : 1'b1;
    end
    out_ready = 1'b1;
    send(16'd7); send(16'd8);
    idle(6);

    // Test 5: reset mid-frame in PAIR
    push(6, 16'hfffc, 0, 0); push(8, 16'hfffc, 1, 0);
    for (int i = 1; i <= 6; i++) send(16'(i));
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_scaled", {31'b0, scaled_valid}, 0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    push(24, 16'hfffc, 0, 0); push(26, 16'hfffc, 1, 0);
    push(28, 16'hfffc, 2, 0); push(30, 16'hfffc, 3, 0);
    for (int i = 10; i <= 17; i++) send(16'(i));
    idle(6);

    // Test 6: back-to-back frames
    push(6, 16'hfffc, 0, 0); push(8, 16'hfffc, 1, 0);
    push(10, 16'hfffc, 2, 0); push(12, 16'hfffc, 3, 0);
    push(22, 16'hfffc, 0, 0); push(24, 16'hfffc, 1, 0);
    push(26, 16'hfffc, 2, 0); push(28, 16'hfffc, 3, 0);
    track = 1; seen = 0; max_gap = 0; out_cnt = 0;
    for (int i = 1; i <= 16; i++) send(16'(i));
    idle(6);
    track = 0;
    chk("b2b_count", out_cnt, 8);
    chk("b2b_gap_ok", {31'b0, (max_gap <= HALF + 1)}, 1);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/haar_butterfly_stage_16bit.md
Name: haar_butterfly_stage_16bit

Overview:
- Upstream feeder for the 16-bit 1/sqrt(2) constant-multiplier stage in the transform datapath.
- Buffers the first half of each N-sample frame, then pairs sample k with sample k+N/2 to produce sum and difference words.
- The difference word goes to the 1/sqrt(2) multiplier.
- Drives the multiplier's en and tracks its pipeline latency to produce a matching scaled_valid.

Parameters:
N, 8, frame length in samples; power of 2, >= 2
MULT_LAT, 3, enabled-cycle latency of the downstream multiplier pipeline (>= 1)
IDXW, max(1, clog2(N/2)), width of the pair index

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-low
in_data  input  16  two's-complement input sample
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
sum_out  output  16  buffered sample + current sample
diff_out  output  16  buffered sample - current sample; feeds multiplier input
out_idx  output  IDXW  pair index k of sum_out/diff_out
out_last  output  1  out_idx == N/2-1
out_valid  output  1  sum_out/diff_out/out_idx valid
out_ready  input  1  consumer accepts output this cycle
mult_en  output  1  enable for downstream multiplier pipeline
scaled_valid  output  1  multiplier output currently holds a valid scaled diff

Behaviour:
- Reset (rst==0 at clk edge):
  - state=FILL, cnt=0.
  - sum_out, diff_out, out_idx, out_last, out_valid = 0.
  - Valid shift register cleared, so scaled_valid=0.
  - Buffer contents are don't-care.
  - Reset mid-frame discards the partial frame; the next accepted sample is frame sample 0.
- Input transfer: in_valid && in_ready at a clk edge.
- FILL state:
  - in_ready=1 unconditionally.
  - Each transfer writes buf[cnt] and increments cnt.
  - The transfer with cnt==N/2-1 moves state to PAIR and clears cnt.
  - A pending output (out_valid=1) is held and drained independently while in FILL.
- PAIR state:
  - in_ready = !out_valid || out_ready.
  - On transfer, the next clk edge registers:
    - sum_out = buf[cnt] + in_data
    - diff_out = buf[cnt] - in_data
    - out_idx = cnt, out_last = (cnt==N/2-1)
    - out_valid = 1
  - Latency is 1 cycle from input transfer to out_valid.
  - The transfer with cnt==N/2-1 returns state to FILL and clears cnt.
- Output handshake:
  - Output transfer: out_valid && out_ready.
  - Without a transfer, out_valid and the data hold stable.
  - On a transfer with no new PAIR input accepted, out_valid drops to 0.
  - Simultaneous output transfer and PAIR input transfer: new data loads, out_valid stays 1 (full throughput, one pair per cycle).
- Arithmetic:
  - 16-bit two's complement; the result is the low 16 bits (wrap-around), no carry-out.
  - Exception: saturation when DB_SAT_EN is defined (see Optional Feature).
- Multiplier tracking:
  - mult_en = out_ready (combinational); the downstream pipeline advances whenever the consumer is ready.
  - Valid shift register, MULT_LAT bits:
    - Shifts only on cycles with mult_en=1.
    - Shift-in bit = out_valid && out_ready.
    - scaled_valid = MSB.
    - Holds when mult_en=0.
- Frame boundaries: back-to-back frames are supported with no idle cycle; the FILL of frame f+1 may begin while frame f's last output is still pending.
- in_valid while in_ready=0: no state change; the sample must be held by the source.

Optional Feature:
DB_SAT_EN
- Defined:
  - Sum and difference are computed at 17 bits and saturated to 16 bits: >0x7FFF -> 0x7FFF, <-0x8000 -> 0x8000.
  - An extra output sat_flag (1 bit) is registered alongside out_valid; it is 1 when either result saturated and is 0 at reset.
- Not defined: wrap-around arithmetic, no sat_flag port.

Test Plan:
1. Reset, N=8, samples 1..8 with in_valid=1 and out_ready=1 -> outputs on 4 consecutive cycles:
   - sum = 6,8,10,12
   - diff = 0xFFFC each
   - out_idx = 0..3
   - out_last only on idx 3
2. Same stream with out_ready=0 for 3 cycles after the first output:
   - out_valid stays 1 and data holds at sum=6.
   - in_ready=0 in PAIR during the stall.
   - After release, the remaining outputs arrive in order with none lost.
3. buf=0x7FFF, in=0x0001 and buf=0x8000, in=0x0001:
   - Without DB_SAT_EN: sum=0x8000, diff=0x7FFF.
   - With DB_SAT_EN: sum=0x7FFF with sat_flag=1; diff=0x8000 with sat_flag=1.
4. MULT_LAT=3, out_ready=1, single output transfer at cycle t -> scaled_valid high at the edge ending cycle t+3 for exactly one cycle. Repeat with out_ready=0 for 2 cycles mid-flight -> scaled_valid delayed by 2 cycles.
5. Reset asserted after 6 samples of a frame (in PAIR, cnt=2):
   - Next cycle: out_valid=0, scaled_valid=0, in_ready=1.
   - Samples 10..17 then produce sum=24,26,28,30 with diff=0xFFFC.
6. Two frames back-to-back (1..8 then 9..16), continuous valid/ready -> 8 outputs. The second frame gives sum=22,24,26,28 and diff=0xFFFC. No gap longer than N/2 cycles between frames' outputs.
